// File: rtl/core2wb_pipe.sv
// core2wb_pipe: Ibex core request port -> pipelined Wishbone B4 master bridge.
// Latency: zero-cycle request issue (comb pass-through), zero-cycle response return.
// Backpressure: core_gnt held low while wb_stall is high or MAX_OUTST transactions are in flight.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   core_req/addr/we/be/wdata     core request side (inputs)
//   core_gnt                      request accepted this cycle
//   core_rvalid/err/rdata         core response side
//   wb_cyc/stb/adr/we/sel/dat_o   Wishbone master outputs
//   wb_dat_i/ack/err/stall        Wishbone master inputs
//   outst                         issued-but-unanswered count (debug)
//
// Optional feature macro: CORE2WB_PIPE_TIMEOUT_EN
//   When defined, a watchdog aborts the bus cycle after TIMEOUT_CYCLES cycles in
//   BUSY with no response and returns one error response per outstanding request.
//   When undefined, the block waits indefinitely and TIMEOUT_CYCLES is unused.

module core2wb_pipe #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MAX_OUTST      = 2,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SW            = DW / 8,
  localparam int OW            = $clog2(MAX_OUTST + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  // core side
  input  logic          core_req,
  input  logic [AW-1:0] core_addr,
  input  logic          core_we,
  input  logic [SW-1:0] core_be,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic          core_err,
  output logic [DW-1:0] core_rdata,
  // wishbone side
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic [AW-1:0] wb_adr,
  output logic          wb_we,
  output logic [SW-1:0] wb_sel,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack,
  input  logic          wb_err,
  input  logic          wb_stall,
  // debug
  output logic [OW-1:0] outst
);

  // Elaboration-time parameter sanity checks.
  if ((DW % 8) != 0) begin : g_bad_dw
    $error("core2wb_pipe: DW must be a multiple of 8");
  end
  if (MAX_OUTST < 1 || MAX_OUTST > 15) begin : g_bad_outst
    $error("core2wb_pipe: MAX_OUTST must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_to
    $error("core2wb_pipe: TIMEOUT_CYCLES must be >= 1");
  end

  localparam logic [OW-1:0] MAX_C = OW'(MAX_OUTST);
  localparam logic [OW-1:0] ONE_C = OW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_nxt;
  logic [OW-1:0] outst_q, outst_nxt;
  logic          can_issue;
  logic          resp;
  logic          in_drain;

  // Request fields are a straight pass-through; only stb/cyc are qualified.
  assign wb_adr     = core_addr;
  assign wb_we      = core_we;
  assign wb_sel     = core_be;
  assign wb_dat_o   = core_wdata;
  assign core_rdata = wb_dat_i;
  assign outst      = outst_q;
  assign in_drain   = (state_q == DRAIN);

`ifdef CORE2WB_PIPE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wdog_q;
  logic          wdog_hit;

  // The watchdog only runs while waiting in BUSY; any response restarts it.
  assign wdog_hit = (state_q == BUSY) && !resp && (wdog_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (state_q != BUSY || resp) begin
      wdog_q <= '0;
    end else if (wdog_q != TO_LAST) begin
      wdog_q <= wdog_q + TW'(1);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // State / counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      outst_q <= '0;
    end else begin
      state_q <= state_nxt;
      outst_q <= outst_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Grant and response in the same cycle cancel out.
    outst_nxt = outst_q;
    if (core_gnt && !resp) begin
      outst_nxt = outst_q + ONE_C;
    end else if (!core_gnt && resp) begin
      outst_nxt = outst_q - ONE_C;
    end

    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (outst_nxt != '0) state_nxt = BUSY;
      end
      BUSY: begin
        if (outst_nxt == '0) begin
          state_nxt = IDLE;
        end
`ifdef CORE2WB_PIPE_TIMEOUT_EN
        else if (wdog_hit) begin
          state_nxt = DRAIN;
        end
`endif
      end
      DRAIN: begin
        if (outst_nxt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: everything is qualified by rst_n so the bus and core see an
  // idle interface for the whole time reset is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    // Uses the registered count, so a response this cycle cannot free a slot
    // for an issue in the same cycle.
    can_issue   = (outst_q < MAX_C) && !in_drain;
    wb_stb      = rst_n && core_req && can_issue;
    core_gnt    = wb_stb && !wb_stall;
    wb_cyc      = rst_n && !in_drain && (core_req || (outst_q != '0));

    if (in_drain) begin
      // Bus is abandoned; synthesise one error response per cycle.
      resp      = rst_n && (outst_q != '0);
      core_err  = resp;
    end else begin
      // Spurious ack/err with nothing outstanding is dropped.
      resp      = rst_n && wb_cyc && (wb_ack || wb_err) && (outst_q != '0);
      core_err  = resp && wb_err;
    end
    core_rvalid = resp;
  end

endmodule

// File: tb/tb_core2wb_pipe.sv
module tb_core2wb_pipe;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_req;
  logic [AW-1:0] core_addr;
  logic          core_we;
  logic [SW-1:0] core_be;
  logic [DW-1:0] core_wdata;
  logic          core_gnt;
  logic          core_rvalid;
  logic          core_err;
  logic [DW-1:0] core_rdata;
  logic          wb_cyc;
  logic          wb_stb;
  logic [AW-1:0] wb_adr;
  logic          wb_we;
  logic [SW-1:0] wb_sel;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack;
  logic          wb_err;
  logic          wb_stall;
  logic [OW-1:0] outst;

  int n_cmp = 0;
  int n_bad = 0;

  core2wb_pipe #(
    .AW(AW), .DW(DW), .MAX_OUTST(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_addr(core_addr), .core_we(core_we),
    .core_be(core_be), .core_wdata(core_wdata), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_err(core_err), .core_rdata(core_rdata),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_adr(wb_adr), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall), .outst(outst)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are then driven 1 time unit after the edge and
  // outputs are sampled 1 more unit later, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; core_req = 1'b1; wb_ack = 1'b1;
    tick(); tick(); settle();
    n_cmp++; if (outst !== 2'd0)     begin n_bad++; $display("FAIL reset_outst: got %0d want 0", outst); end
    n_cmp++; if (wb_cyc !== 1'b0)    begin n_bad++; $display("FAIL reset_cyc: got %b want 0", wb_cyc); end
    n_cmp++; if (wb_stb !== 1'b0)    begin n_bad++; $display("FAIL reset_stb: got %b want 0", wb_stb); end
    n_cmp++; if (core_gnt !== 1'b0)  begin n_bad++; $display("FAIL reset_gnt: got %b want 0", core_gnt); end
    n_cmp++; if (core_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", core_rvalid); end
    rst_n = 1'b1; core_req = 1'b0; wb_ack = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    core_req = 1'b1; core_addr = 32'h100; core_we = 1'b0; core_be = 4'hF; core_wdata = 32'h0;
    settle();
    n_cmp++; if (core_gnt !== 1'b1)  begin n_bad++; $display("FAIL rd_gnt: got %b want 1", core_gnt); end
    n_cmp++; if (wb_adr !== 32'h100) begin n_bad++; $display("FAIL rd_adr: got %h want 00000100", wb_adr); end
    n_cmp++; if (wb_sel !== 4'hF)    begin n_bad++; $display("FAIL rd_sel: got %h want f", wb_sel); end
    tick();
    core_req = 1'b0; settle();
    n_cmp++; if (outst !== 2'd1)     begin n_bad++; $display("FAIL rd_outst1: got %0d want 1", outst); end
    n_cmp++; if (core_gnt !== 1'b0)  begin n_bad++; $display("FAIL rd_gnt_once: got %b want 0", core_gnt); end
    n_cmp++; if (wb_cyc !== 1'b1)    begin n_bad++; $display("FAIL rd_cyc_wait: got %b want 1", wb_cyc); end
    tick();
    wb_ack = 1'b1; wb_dat_i = 32'hDEADBEEF; settle();
    n_cmp++; if (core_rvalid !== 1'b1) begin n_bad++; $display("FAIL rd_rvalid: got %b want 1", core_rvalid); end
    n_cmp++; if (core_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_rdata: got %h want deadbeef", core_rdata); end
    n_cmp++; if (core_err !== 1'b0)  begin n_bad++; $display("FAIL rd_err: got %b want 0", core_err); end
    tick();
    wb_ack = 1'b0; settle();
    n_cmp++; if (outst !== 2'd0)     begin n_bad++; $display("FAIL rd_outst0: got %0d want 0", outst); end
    n_cmp++; if (wb_cyc !== 1'b0)    begin n_bad++; $display("FAIL rd_cyc_fall: got %b want 0", wb_cyc); end
    n_cmp++; if (core_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_rvalid_once: got %b want 0", core_rvalid); end
  endtask

  task automatic test_back_to_back();
    core_req = 1'b1; core_addr = 32'h200; core_we = 1'b1; core_wdata = 32'h11223344;
    settle();
    n_cmp++; if (core_gnt !== 1'b1)  begin n_bad++; $display("FAIL b2b_gnt1: got %b want 1", core_gnt); end
    n_cmp++; if (wb_we !== 1'b1 || wb_dat_o !== 32'h11223344) begin n_bad++; $display("FAIL b2b_wr_pass: got we=%b dat=%h want we=1 dat=11223344", wb_we, wb_dat_o); end
    tick(); core_addr = 32'h204; settle();
    n_cmp++; if (core_gnt !== 1'b1)  begin n_bad++; $display("FAIL b2b_gnt2: got %b want 1", core_gnt); end
    tick(); core_addr = 32'h208; settle();
    n_cmp++; if (outst !== 2'd2)     begin n_bad++; $display("FAIL b2b_outst2: got %0d want 2", outst); end
    n_cmp++; if (wb_stb !== 1'b0 || core_gnt !== 1'b0) begin n_bad++; $display("FAIL b2b_full: got stb=%b gnt=%b want 0 0", wb_stb, core_gnt); end
    n_cmp++; if (wb_cyc !== 1'b1)    begin n_bad++; $display("FAIL b2b_cyc_full: got %b want 1", wb_cyc); end
    tick(); wb_ack = 1'b1; settle();
    // The ack frees a slot only from the next cycle on.
    n_cmp++; if (core_rvalid !== 1'b1 || core_gnt !== 1'b0) begin n_bad++; $display("FAIL b2b_ack_nofree: got rvalid=%b gnt=%b want 1 0", core_rvalid, core_gnt); end
    tick(); wb_ack = 1'b0; settle();
    n_cmp++; if (outst !== 2'd1)     begin n_bad++; $display("FAIL b2b_outst_dec: got %0d want 1", outst); end
    n_cmp++; if (core_gnt !== 1'b1)  begin n_bad++; $display("FAIL b2b_gnt3: got %b want 1", core_gnt); end
    tick(); core_req = 1'b0; wb_ack = 1'b1; settle();
    n_cmp++; if (outst !== 2'd2)     begin n_bad++; $display("FAIL b2b_outst_refill: got %0d want 2", outst); end
    tick(); tick(); wb_ack = 1'b0; settle();
    n_cmp++; if (outst !== 2'd0 || wb_cyc !== 1'b0) begin n_bad++; $display("FAIL b2b_done: got outst=%0d cyc=%b want 0 0", outst, wb_cyc); end
  endtask

  task automatic test_stall();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h300; wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_cmp++; if (core_gnt !== 1'b0 || wb_stb !== 1'b1 || outst !== 2'd0) begin
        n_bad++; $display("FAIL stall_hold%0d: got gnt=%b stb=%b outst=%0d want 0 1 0", i, core_gnt, wb_stb, outst);
      end
      tick();
    end
    wb_stall = 1'b0; settle();
    n_cmp++; if (core_gnt !== 1'b1)  begin n_bad++; $display("FAIL stall_release: got %b want 1", core_gnt); end
    tick(); core_req = 1'b0; settle();
    n_cmp++; if (outst !== 2'd1)     begin n_bad++; $display("FAIL stall_outst: got %0d want 1", outst); end
  endtask

  task automatic test_error_and_simul();
    // outst is 1 on entry
    wb_ack = 1'b1; wb_err = 1'b1; settle();
    n_cmp++; if (core_rvalid !== 1'b1 || core_err !== 1'b1) begin n_bad++; $display("FAIL err_ackerr: got rvalid=%b err=%b want 1 1", core_rvalid, core_err); end
    tick(); wb_ack = 1'b0; wb_err = 1'b0; core_req = 1'b1; settle();
    n_cmp++; if (outst !== 2'd0)     begin n_bad++; $display("FAIL err_outst0: got %0d want 0", outst); end
    tick(); wb_ack = 1'b1; settle();
    n_cmp++; if (core_gnt !== 1'b1 || core_rvalid !== 1'b1) begin n_bad++; $display("FAIL simul_both: got gnt=%b rvalid=%b want 1 1", core_gnt, core_rvalid); end
    tick(); core_req = 1'b0; wb_ack = 1'b0; settle();
    n_cmp++; if (outst !== 2'd1)     begin n_bad++; $display("FAIL simul_outst: got %0d want 1", outst); end
    wb_ack = 1'b1; tick(); wb_ack = 1'b0; settle();
    n_cmp++; if (outst !== 2'd0)     begin n_bad++; $display("FAIL simul_clear: got %0d want 0", outst); end
  endtask

  task automatic test_spurious_and_reset();
    wb_ack = 1'b1; settle();
    n_cmp++; if (core_rvalid !== 1'b0) begin n_bad++; $display("FAIL spur_rvalid: got %b want 0", core_rvalid); end
    tick(); wb_ack = 1'b0; settle();
    n_cmp++; if (outst !== 2'd0)     begin n_bad++; $display("FAIL spur_outst: got %0d want 0", outst); end
    core_req = 1'b1; tick(); tick(); core_req = 1'b0; settle();
    n_cmp++; if (outst !== 2'd2)     begin n_bad++; $display("FAIL rst_pre_outst: got %0d want 2", outst); end
    rst_n = 1'b0; tick(); rst_n = 1'b1; settle();
    n_cmp++; if (outst !== 2'd0 || wb_cyc !== 1'b0) begin n_bad++; $display("FAIL rst_mid: got outst=%0d cyc=%b want 0 0", outst, wb_cyc); end
    wb_ack = 1'b1; settle();
    n_cmp++; if (core_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_discard: got %b want 0", core_rvalid); end
    tick(); wb_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int waited;
    core_req = 1'b1; tick(); tick(); core_req = 1'b0; settle();
    n_cmp++; if (outst !== 2'd2)     begin n_bad++; $display("FAIL to_pre_outst: got %0d want 2", outst); end
`ifdef CORE2WB_PIPE_TIMEOUT_EN
    waited = 0;
    while (wb_cyc === 1'b1 && waited < 20) begin
      tick(); settle(); waited++;
    end
    n_cmp++; if (wb_cyc !== 1'b0 || waited > 10) begin n_bad++; $display("FAIL to_abort: got cyc=%b after %0d cycles want 0 within 10", wb_cyc, waited); end
    wb_ack = 1'b1; // ignored while draining
    settle();
    n_cmp++; if (core_rvalid !== 1'b1 || core_err !== 1'b1 || core_gnt !== 1'b0) begin n_bad++; $display("FAIL to_pulse1: got rvalid=%b err=%b gnt=%b want 1 1 0", core_rvalid, core_err, core_gnt); end
    tick(); settle();
    n_cmp++; if (core_rvalid !== 1'b1 || core_err !== 1'b1) begin n_bad++; $display("FAIL to_pulse2: got rvalid=%b err=%b want 1 1", core_rvalid, core_err); end
    tick(); wb_ack = 1'b0; settle();
    n_cmp++; if (core_rvalid !== 1'b0 || outst !== 2'd0) begin n_bad++; $display("FAIL to_idle: got rvalid=%b outst=%0d want 0 0", core_rvalid, outst); end
`else
    waited = 0;
    repeat (300) begin tick(); waited++; end
    settle();
    n_cmp++; if (outst !== 2'd2 || wb_cyc !== 1'b1 || core_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL to_wait: got outst=%0d cyc=%b rvalid=%b after %0d cycles want 2 1 0", outst, wb_cyc, core_rvalid, waited);
    end
    wb_ack = 1'b1; tick(); tick(); wb_ack = 1'b0; settle();
    n_cmp++; if (outst !== 2'd0)     begin n_bad++; $display("FAIL to_clear: got %0d want 0", outst); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; core_req = 1'b0; core_addr = '0; core_we = 1'b0;
    core_be = 4'hF; core_wdata = '0; wb_dat_i = '0;
    wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_stall();
    test_error_and_simul();
    test_spurious_and_reset();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core2wb_pipe.md
Name: core2wb_pipe

Overview:
- Parametrised successor bridge between the Ibex LSU/IF core request interface and a pipelined Wishbone B4 master port.
- Supports up to MAX_OUTST outstanding transactions, configurable address/data width, and holds cyc across back-to-back bursts.
- Sits between each Ibex core port (instr or data) and the system Wishbone interconnect.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; must be a multiple of 8; SW = DW/8.
- MAX_OUTST, 2, maximum issued-but-unanswered transactions (1..15).
- TIMEOUT_CYCLES, 255, cycles without a response before abort (used only with the optional feature; must be ≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- core_req  in  1  core request.
- core_addr  in  AW  request address.
- core_we  in  1  write enable.
- core_be  in  SW  byte enables.
- core_wdata  in  DW  write data.
- core_gnt  out  1  request accepted this cycle.
- core_rvalid  out  1  response valid.
- core_err  out  1  response is an error (qualified by core_rvalid).
- core_rdata  out  DW  read data.
- wb_cyc  out  1  bus cycle.
- wb_stb  out  1  strobe.
- wb_adr  out  AW  address.
- wb_we  out  1  write enable.
- wb_sel  out  SW  byte select.
- wb_dat_o  out  DW  write data.
- wb_dat_i  in  DW  read data.
- wb_ack  in  1  acknowledge.
- wb_err  in  1  error.
- wb_stall  in  1  pipeline stall.
- outst  out  $clog2(MAX_OUTST+1)  current outstanding count (debug).

Behaviour:
- Reset (rst_n low at a clk edge): outst=0, cyc register=0, state=IDLE. All outputs are combinational from these registers and inputs, so wb_cyc/wb_stb/core_gnt/core_rvalid are 0 while rst_n is low. Reset mid-transaction discards all outstanding responses; no core_rvalid is produced for them.
- Issue: can_issue = (outst < MAX_OUTST) & state!=DRAIN. wb_stb = core_req & can_issue. core_gnt = wb_stb & ~wb_stall. wb_adr/we/sel/dat_o pass core_* through combinationally.
- Response: resp = wb_cyc & (wb_ack | wb_err) & (outst != 0). core_rvalid = resp; core_err = resp & wb_err; core_rdata = wb_dat_i. ack and err together: treated as error. Zero latency from bus to core.
- Spurious ack/err with outst==0 is ignored, not forwarded, and does not change the count.
- Counter: outst += core_gnt; outst -= resp; simultaneous grant and response leave outst unchanged. A response in the same cycle does not free a slot for that cycle's issue (can_issue uses registered outst).
- wb_cyc = core_req | (outst != 0), gated by state!=DRAIN. cyc stays high across back-to-back requests and deasserts the cycle after the last response when core_req is low.
- States: IDLE (outst==0), BUSY (outst>0), DRAIN (feature only). IDLE→BUSY on grant; BUSY→IDLE when outst reaches 0.
- Full: at outst==MAX_OUTST, wb_stb=0 and core_gnt=0 while core_req is held; wb_cyc remains 1.

Optional Feature:
- Macro: CORE2WB_PIPE_TIMEOUT_EN.
- Defined: a watchdog counts cycles in BUSY with no resp and clears on each resp. When it reaches TIMEOUT_CYCLES, the block enters DRAIN:
  - wb_cyc=0 and wb_stb=0 (bus cycle aborted);
  - core_gnt=0;
  - one core_rvalid=1, core_err=1 per cycle until outst==0, then IDLE;
  - wb_ack/wb_err during DRAIN are ignored.
- Not defined: no watchdog, DRAIN unreachable, and TIMEOUT_CYCLES is unused.

Test Plan:
- Single read: req addr 0x100, stall=0, ack 2 cycles later with dat_i 0xDEADBEEF → gnt 1 cycle, rvalid 1 cycle with rdata 0xDEADBEEF and err 0, cyc falls 1 cycle after ack, outst 0→1→0.
- Back-to-back: MAX_OUTST=2, 3 requests held, no ack → first 2 granted, 3rd stalled with stb=0 and cyc=1. Ack → outst 2→1, then 3rd granted the next cycle.
- Stall: wb_stall=1 for 3 cycles with req high → gnt=0, stb=1, outst=0. Stall drops → gnt 1 cycle.
- Error and simultaneous events: wb_err and wb_ack in same cycle → rvalid=1, err=1. Grant plus ack in same cycle → outst unchanged.
- Spurious ack with outst=0 → rvalid stays 0. Reset asserted with outst=2 → next cycle outst=0, cyc=0, and a later ack produces no rvalid.
- Timeout (with CORE2WB_PIPE_TIMEOUT_EN, TIMEOUT_CYCLES=8): 2 outstanding with no ack for 8 cycles → cyc=0, 2 consecutive rvalid+err pulses, then IDLE. Without the macro → block waits indefinitely.
